// File: rtl/matrix_loader.sv
// matrix_loader: streams operand elements into the matrix multiplier's
// mat1/mat2 stores (row-major), pulses start, then waits for done.
// Optional framing check on in_last: define MATRIX_LOADER_LAST_CHECK_EN.
module matrix_loader #(
    parameter int ROW1  = 3,
    parameter int COL1  = 3,
    parameter int COL2  = 3,
    parameter int WIDTH = 16,
    localparam int N1   = ROW1 * COL1,
    localparam int N2   = COL1 * COL2,
    localparam int NMAX = (N1 > N2) ? N1 : N2,
    localparam int AW   = (NMAX > 1) ? $clog2(NMAX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             wr_en,
    output logic             wr_sel,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             start,
    input  logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        LOAD1 = 2'd0,
        LOAD2 = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST1 = AW'(N1 - 1);
    localparam logic [AW-1:0] LAST2 = AW'(N2 - 1);

    state_t        state, next_state;
    logic [AW-1:0] cnt, cnt_next;
    logic          accept;
    logic          at_end;
    logic          frame_err;
    logic          ready_d;
    logic          start_d;

    assign accept = in_valid & in_ready;
    assign at_end = (state == LOAD2) ? (cnt == LAST2) : (cnt == LAST1);

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    // in_last must coincide exactly with the final beat of each matrix
    assign frame_err = accept & (in_last != at_end);
`else
    logic unused_in_last;
    assign frame_err      = 1'b0;
    assign unused_in_last = in_last;
    assign err            = 1'b0;
`endif

    // State and element counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD1;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            LOAD1, LOAD2: begin
                if (accept) begin
                    if (frame_err) begin
                        next_state = LOAD1;
                        cnt_next   = '0;
                    end else if (at_end) begin
                        next_state = (state == LOAD1) ? LOAD2 : START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            START:   next_state = WAIT;
            WAIT:    if (done) next_state = LOAD1;
            default: next_state = LOAD1;
        endcase
    end

    // Output decode: in_ready and start are registered from the next state,
    // so in_ready drops on the same edge that accepts the final mat2 beat
    always_comb begin
        ready_d = (next_state == LOAD1) || (next_state == LOAD2);
        start_d = (next_state == START);
    end

    // Registered handshake, start pulse and store write bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            start    <= 1'b0;
            wr_en    <= 1'b0;
            wr_sel   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            in_ready <= ready_d;
            start    <= start_d;
            wr_en    <= accept;
            if (accept) begin
                wr_sel  <= (state == LOAD2);
                wr_addr <= cnt;
                wr_data <= in_data;
            end
        end
    end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    // Sticky framing error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (frame_err) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
